dma_ch_sched: RTL and testbench
===============================

Name: dma_ch_sched

Overview:
Multi-channel scheduler in front of the single DMA engine (FSM, streamers, FIFO, AXI interface).
- Up to NUM_CH software channels each present one pending descriptor.
- The block arbitrates round-robin, loads the winner's descriptor into the engine, and issues a one-cycle start.
- It then supervises completion, error and timeout, aborting the engine on timeout, and reports per-channel done/error pulses.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
DESC_W, 495, descriptor width forwarded to engine
TMO_W, 16, width of timeout counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ch_req_i  in  NUM_CH  level, channel has valid descriptor
ch_desc_i  in  NUM_CH*DESC_W  descriptors; channel n at [n*DESC_W +: DESC_W]
ch_grant_o  out  NUM_CH  one-hot pulse, descriptor captured
ch_done_o  out  NUM_CH  one-hot pulse, transfer completed OK
ch_err_o  out  NUM_CH  one-hot pulse, engine error or timeout
eng_desc_o  out  DESC_W  captured descriptor, stable from LOAD until return to IDLE
eng_go_o  out  1  one-cycle start pulse
eng_abort_o  out  1  level abort request
eng_busy_i  in  1  engine active
eng_done_i  in  1  pulse, transfer finished
eng_err_i  in  1  pulse, transfer error
tmo_cyc_i  in  TMO_W  RUN-state timeout in cycles; 0 = disabled
busy_o  out  1  high in any state except IDLE
cur_ch_o  out  clog2(NUM_CH)  channel being served (valid while busy_o)

Behaviour:
- Interface: one clock clk; reset rst is synchronous, active-high.
- Reset values: all outputs 0, state IDLE, RR pointer 0, timeout counter 0. Reset mid-transfer drops everything next edge; no abort is issued because the engine shares rst.
- States: IDLE, LOAD, GO, RUN, ABORT, DRAIN.
- IDLE: if any ch_req_i bit is set, pick the first requester at or after the RR pointer (wrapping) -> LOAD. Otherwise stay.
- LOAD (1 cycle):
  - latch ch_desc_i[winner] into eng_desc_o and winner into cur_ch_o;
  - ch_grant_o[winner]=1;
  - RR pointer <= winner+1 mod NUM_CH;
  - -> GO.
- Grant/request contract: the requester must drop or replace ch_req_i the cycle after grant; changes to ch_desc_i after LOAD have no effect.
- GO (1 cycle): eng_go_o=1; timeout counter cleared -> RUN.
- RUN:
  - eng_err_i -> ch_err_o[cur]=1 next cycle -> DRAIN.
  - Else eng_done_i -> ch_done_o[cur]=1 -> IDLE.
  - Else if tmo_cyc_i!=0 and counter==tmo_cyc_i-1 -> ABORT.
  - Else counter+1, saturating at all-ones.
  - err and done in the same cycle: err wins, no done pulse.
- ABORT: eng_abort_o=1 held; when eng_busy_i==0 -> ch_err_o[cur]=1, drop abort -> IDLE. eng_done_i/eng_err_i in ABORT are ignored.
- DRAIN: wait for eng_busy_i==0 -> IDLE, so the engine has cleared before the next GO.
- eng_done_i/eng_err_i outside RUN/ABORT are ignored.
- Latency:
  - request to eng_go_o is 2 cycles (LOAD, GO);
  - eng_done_i to ch_done_o is 1 cycle;
  - minimum back-to-back spacing (done to next go) is 3 cycles.
- Fairness: with all channels requesting, the grant order is 0,1,2,3,0,...; the pointer advances only on grant.

Optional Feature:
DMA_SCHED_PRIO_EN
- Defined:
  - adds input ch_prio_i [NUM_CH];
  - in IDLE, if any requester has prio=1, arbitration is RR among high-prio requesters only;
  - low-prio requesters are served only when no high-prio request is pending;
  - both classes share the single RR pointer.
- Undefined: port absent, pure RR as above.

Test Plan:
- Single channel: ch_req_i=0b0010, eng_done_i 10 cycles after go -> ch_grant_o=0b0010 at LOAD, eng_go_o 1 cycle later, eng_desc_o==ch_desc_i[1], ch_done_o=0b0010 one cycle after done, busy_o back to 0.
- All four request continuously, engine finishes each in 5 cycles -> grants 0,1,2,3,0 in order, each done pulse on the matching channel, never two grants without an intervening done.
- Timeout: tmo_cyc_i=8, engine never signals done, eng_busy_i drops 3 cycles after abort:
  - eng_abort_o rises 8 cycles after RUN entry and holds 3 cycles;
  - ch_err_o[cur] pulses;
  - next grant follows.
- eng_err_i and eng_done_i in the same cycle on channel 2, eng_busy_i low 2 cycles later -> ch_err_o=0b0100, ch_done_o stays 0, DRAIN exit after busy drops.
- rst asserted during RUN -> next cycle all outputs 0, RR pointer 0; with ch_req_i=0b1001 after release, channel 0 is granted first.
- (DMA_SCHED_PRIO_EN) ch_req_i=0b1111, ch_prio_i=0b1000 -> channel 3 is granted repeatedly while its request persists; channels 0..2 are granted only after ch_prio_i is cleared.

Source files
------------

// File: rtl/dma_ch_sched_if.sv
// Channel and engine signal bundle for dma_ch_sched.
// ch_prio_i exists only when DMA_SCHED_PRIO_EN is defined.
interface dma_ch_sched_if #(
    parameter int NUM_CH = 4,
    parameter int DESC_W = 495,
    parameter int TMO_W  = 16
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]        ch_req_i;
    logic [NUM_CH*DESC_W-1:0] ch_desc_i;
`ifdef DMA_SCHED_PRIO_EN
    logic [NUM_CH-1:0]        ch_prio_i;
`endif
    logic [NUM_CH-1:0]        ch_grant_o;
    logic [NUM_CH-1:0]        ch_done_o;
    logic [NUM_CH-1:0]        ch_err_o;
    logic [DESC_W-1:0]        eng_desc_o;
    logic                     eng_go_o;
    logic                     eng_abort_o;
    logic                     eng_busy_i;
    logic                     eng_done_i;
    logic                     eng_err_i;
    logic [TMO_W-1:0]         tmo_cyc_i;
    logic                     busy_o;
    logic [CH_W-1:0]          cur_ch_o;

    modport slave (
`ifdef DMA_SCHED_PRIO_EN
        input  ch_prio_i,
`endif
        input  ch_req_i, ch_desc_i, eng_busy_i, eng_done_i, eng_err_i, tmo_cyc_i,
        output ch_grant_o, ch_done_o, ch_err_o, eng_desc_o, eng_go_o, eng_abort_o,
               busy_o, cur_ch_o
    );

    modport master (
`ifdef DMA_SCHED_PRIO_EN
        output ch_prio_i,
`endif
        output ch_req_i, ch_desc_i, eng_busy_i, eng_done_i, eng_err_i, tmo_cyc_i,
        input  ch_grant_o, ch_done_o, ch_err_o, eng_desc_o, eng_go_o, eng_abort_o,
               busy_o, cur_ch_o
    );
endinterface

// File: rtl/dma_ch_sched.sv
// Round-robin channel scheduler in front of the single DMA engine; supervises done/error/timeout.
// Optional DMA_SCHED_PRIO_EN: high-priority requesters win arbitration over low-priority ones.
//
// state | meaning
// IDLE  | waiting for a request, arbitrating
// LOAD  | descriptor captured, grant pulse
// GO    | engine start pulse, timeout counter cleared
// RUN   | engine working, watching done/err/timeout
// ABORT | abort held until engine goes idle
// DRAIN | after engine error, wait for engine idle
module dma_ch_sched #(
    parameter int NUM_CH = 4,
    parameter int DESC_W = 495,
    parameter int TMO_W  = 16
) (
    input logic           clk,
    input logic           rst,
    dma_ch_sched_if.slave bus
);
    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GO,
        S_RUN,
        S_ABORT,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   rr_q;
    logic [CH_W-1:0]   cur_q;
    logic [CH_W-1:0]   win;
    logic              win_vld;
    logic [NUM_CH-1:0] arb_req;
    logic [NUM_CH-1:0] cur_mask;
    logic [DESC_W-1:0] desc_q;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_last;
    logic              tmo_hit;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [NUM_CH-1:0] err_q, err_d;

    function automatic logic [CH_W-1:0] rot_idx(input logic [CH_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CH) s = s - NUM_CH;
        return CH_W'(s);
    endfunction

`ifdef DMA_SCHED_PRIO_EN
    always_comb begin
        arb_req = bus.ch_req_i;
        if (|(bus.ch_req_i & bus.ch_prio_i)) arb_req = bus.ch_req_i & bus.ch_prio_i;
    end
`else
    always_comb begin
        arb_req = bus.ch_req_i;
    end
`endif

    // First requester at or after the RR pointer, wrapping.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!win_vld && arb_req[rot_idx(rr_q, i)]) begin
                win     = rot_idx(rr_q, i);
                win_vld = 1'b1;
            end
        end
    end

    assign cur_mask = NUM_CH'(1) << cur_q;
    assign tmo_last = bus.tmo_cyc_i - TMO_W'(1);
    assign tmo_hit  = (bus.tmo_cyc_i != '0) && (cnt_q == tmo_last);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = '0;
        err_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (win_vld) state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_GO;
            end
            S_GO: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // Error takes precedence over a coincident done.
                if (bus.eng_err_i) begin
                    err_d   = cur_mask;
                    state_d = S_DRAIN;
                end else if (bus.eng_done_i) begin
                    done_d  = cur_mask;
                    state_d = S_IDLE;
                end else if (tmo_hit) begin
                    state_d = S_ABORT;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end
            S_ABORT: begin
                if (!bus.eng_busy_i) begin
                    err_d   = cur_mask;
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (!bus.eng_busy_i) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            cur_q   <= '0;
            desc_q  <= '0;
            cnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (state_q == S_IDLE && win_vld) begin
                cur_q  <= win;
                desc_q <= bus.ch_desc_i[int'(win)*DESC_W +: DESC_W];
            end
            if (state_q == S_LOAD) rr_q <= rot_idx(cur_q, 1);
        end
    end

    assign bus.ch_grant_o  = (state_q == S_LOAD) ? cur_mask : '0;
    assign bus.ch_done_o   = done_q;
    assign bus.ch_err_o    = err_q;
    assign bus.eng_desc_o  = desc_q;
    assign bus.eng_go_o    = (state_q == S_GO);
    assign bus.eng_abort_o = (state_q == S_ABORT);
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.cur_ch_o    = cur_q;
endmodule

// File: tb/tb_dma_ch_sched.sv
// Scoreboard bench for dma_ch_sched: directed stimulus pushes expected events, a negedge monitor pops them.
module tb_dma_ch_sched;
    localparam int NUM_CH = 4;
    localparam int DESC_W = 495;
    localparam int TMO_W  = 16;

    typedef enum int {EV_GRANT, EV_GO, EV_DONE, EV_ERR, EV_ABORT} ev_kind_t;
    typedef struct {
        ev_kind_t          kind;
        int                ch;
        int                cyc;
        logic [DESC_W-1:0] desc;
    } ev_t;

    ev_t  exp_q[$];
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   tag = 0;
    logic abort_prev = 1'b0;

    dma_ch_sched_if #(.NUM_CH(NUM_CH), .DESC_W(DESC_W), .TMO_W(TMO_W)) bus ();

    dma_ch_sched #(.NUM_CH(NUM_CH), .DESC_W(DESC_W), .TMO_W(TMO_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DESC_W-1:0] mk_desc(input int ch, input int t);
        logic [511:0] w;
        for (int j = 0; j < 16; j++) w[j*32 +: 32] = {8'(t), 8'(ch), 8'(j), 8'hA5};
        return w[DESC_W-1:0];
    endfunction

    task automatic set_descs(input int t);
        tag = t;
        for (int c = 0; c < NUM_CH; c++) bus.ch_desc_i[c*DESC_W +: DESC_W] = mk_desc(c, t);
    endtask

    task automatic expect_ev(input ev_kind_t k, input int ch, input int c);
        ev_t e;
        e.kind = k;
        e.ch   = ch;
        e.cyc  = c;
        e.desc = (ch >= 0) ? mk_desc(ch, tag) : '0;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [DESC_W-1:0] got, input logic [DESC_W-1:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cyc %0d)", name, got, req, cyc);
        end
    endtask

    task automatic observe(input ev_kind_t k, input logic [NUM_CH-1:0] m);
        ev_t               e;
        logic [NUM_CH-1:0] em;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got mask=%b at cyc %0d, required no event", k.name(), m, cyc);
            return;
        end
        e  = exp_q.pop_front();
        em = (e.ch >= 0) ? NUM_CH'(1) << e.ch : '0;
        if (e.kind != k || em != m || e.cyc != cyc) begin
            errors++;
            $display("FAIL event_%s: got %s mask=%b cyc=%0d, required %s mask=%b cyc=%0d",
                     e.kind.name(), k.name(), m, cyc, e.kind.name(), em, e.cyc);
        end else if (k == EV_GRANT) begin
            checks++;
            if (bus.eng_desc_o !== e.desc || int'(bus.cur_ch_o) != e.ch) begin
                errors++;
                $display("FAIL grant_capture: got ch=%0d desc=%0h required ch=%0d desc=%0h",
                         bus.cur_ch_o, bus.eng_desc_o, e.ch, e.desc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.ch_grant_o != '0) observe(EV_GRANT, bus.ch_grant_o);
        if (bus.eng_go_o === 1'b1) observe(EV_GO, '0);
        if (bus.ch_done_o != '0) observe(EV_DONE, bus.ch_done_o);
        if (bus.ch_err_o != '0) observe(EV_ERR, bus.ch_err_o);
        if (bus.eng_abort_o === 1'b1 && !abort_prev) observe(EV_ABORT, '0);
        abort_prev = (bus.eng_abort_o === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int s;
        rst             = 1'b1;
        bus.ch_req_i    = '0;
        bus.eng_busy_i  = 1'b0;
        bus.eng_done_i  = 1'b0;
        bus.eng_err_i   = 1'b0;
        bus.tmo_cyc_i   = '0;
`ifdef DMA_SCHED_PRIO_EN
        bus.ch_prio_i   = '0;
`endif
        set_descs(1);
        wait_cyc(3);
        check("rst_busy", bus.busy_o, 0);
        check("rst_cur_ch", bus.cur_ch_o, 0);
        check("rst_desc", bus.eng_desc_o, 0);
        check("rst_outs", {bus.ch_grant_o, bus.ch_done_o, bus.ch_err_o, bus.eng_go_o, bus.eng_abort_o}, 0);
        rst = 1'b0;

        // Fairness: all four requesting, engine done 5 cycles after go.
        s = cyc;
        bus.ch_req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            expect_ev(EV_GRANT, k % 4, s + 1 + 8*k);
            expect_ev(EV_GO, -1, s + 2 + 8*k);
            expect_ev(EV_DONE, k % 4, s + 8 + 8*k);
        end
        for (int k = 0; k < 5; k++) begin
            wait_cyc(s + 2 + 8*k);
            bus.eng_busy_i = 1'b1;
            if (k == 4) bus.ch_req_i = '0;
            wait_cyc(s + 7 + 8*k);
            bus.eng_done_i = 1'b1;
            bus.eng_busy_i = 1'b0;
            wait_cyc(s + 8 + 8*k);
            bus.eng_done_i = 1'b0;
        end
        wait_cyc(s + 42);
        bus.eng_done_i = 1'b1;
        bus.eng_err_i  = 1'b1;
        wait_cyc(s + 43);
        bus.eng_done_i = 1'b0;
        bus.eng_err_i  = 1'b0;
        check("idle_ignores_done", bus.busy_o, 0);
        wait_cyc(s + 45);

        // Single channel 1, done 10 cycles after go; descriptor changes after LOAD are ignored.
        s = cyc;
        set_descs(2);
        bus.ch_req_i = 4'b0010;
        expect_ev(EV_GRANT, 1, s + 1);
        expect_ev(EV_GO, -1, s + 2);
        expect_ev(EV_DONE, 1, s + 13);
        wait_cyc(s + 2);
        bus.ch_req_i   = '0;
        bus.eng_busy_i = 1'b1;
        set_descs(3);
        wait_cyc(s + 5);
        check("desc_held", bus.eng_desc_o, mk_desc(1, 2));
        check("cur_ch_run", bus.cur_ch_o, 1);
        check("busy_run", bus.busy_o, 1);
        wait_cyc(s + 12);
        bus.eng_done_i = 1'b1;
        bus.eng_busy_i = 1'b0;
        wait_cyc(s + 13);
        bus.eng_done_i = 1'b0;
        check("busy_after_done", bus.busy_o, 0);
        wait_cyc(s + 15);

        // Timeout on channel 3, busy drops on the third abort cycle, then channel 0 follows.
        s = cyc;
        bus.ch_req_i  = 4'b1000;
        bus.tmo_cyc_i = 16'd8;
        expect_ev(EV_GRANT, 3, s + 1);
        expect_ev(EV_GO, -1, s + 2);
        expect_ev(EV_ABORT, -1, s + 11);
        expect_ev(EV_ERR, 3, s + 14);
        expect_ev(EV_GRANT, 0, s + 15);
        expect_ev(EV_GO, -1, s + 16);
        expect_ev(EV_DONE, 0, s + 21);
        wait_cyc(s + 2);
        bus.ch_req_i   = '0;
        bus.eng_busy_i = 1'b1;
        wait_cyc(s + 10);
        check("abort_before_tmo", bus.eng_abort_o, 0);
        wait_cyc(s + 11);
        check("abort_at_tmo", bus.eng_abort_o, 1);
        wait_cyc(s + 12);
        bus.eng_done_i = 1'b1;
        bus.ch_req_i   = 4'b0001;
        wait_cyc(s + 13);
        bus.eng_done_i = 1'b0;
        bus.eng_busy_i = 1'b0;
        check("abort_held", bus.eng_abort_o, 1);
        wait_cyc(s + 14);
        check("abort_dropped", bus.eng_abort_o, 0);
        wait_cyc(s + 16);
        bus.ch_req_i   = '0;
        bus.eng_busy_i = 1'b1;
        bus.tmo_cyc_i  = '0;
        wait_cyc(s + 20);
        bus.eng_done_i = 1'b1;
        bus.eng_busy_i = 1'b0;
        wait_cyc(s + 21);
        bus.eng_done_i = 1'b0;
        wait_cyc(s + 23);

        // Error and done together on channel 2: error wins, DRAIN until busy drops.
        s = cyc;
        bus.ch_req_i = 4'b0100;
        expect_ev(EV_GRANT, 2, s + 1);
        expect_ev(EV_GO, -1, s + 2);
        expect_ev(EV_ERR, 2, s + 7);
        wait_cyc(s + 2);
        bus.ch_req_i   = '0;
        bus.eng_busy_i = 1'b1;
        wait_cyc(s + 6);
        bus.eng_err_i  = 1'b1;
        bus.eng_done_i = 1'b1;
        wait_cyc(s + 7);
        bus.eng_err_i  = 1'b0;
        bus.eng_done_i = 1'b0;
        check("drain_busy", bus.busy_o, 1);
        wait_cyc(s + 8);
        bus.eng_busy_i = 1'b0;
        check("drain_hold", bus.busy_o, 1);
        wait_cyc(s + 9);
        check("drain_exit", bus.busy_o, 0);
        wait_cyc(s + 11);

        // Reset during RUN, then 0b1001 must grant channel 0 first.
        s = cyc;
        bus.ch_req_i = 4'b0010;
        expect_ev(EV_GRANT, 1, s + 1);
        expect_ev(EV_GO, -1, s + 2);
        wait_cyc(s + 2);
        bus.ch_req_i   = '0;
        bus.eng_busy_i = 1'b1;
        wait_cyc(s + 4);
        rst = 1'b1;
        wait_cyc(s + 5);
        check("midrst_busy", bus.busy_o, 0);
        check("midrst_cur_ch", bus.cur_ch_o, 0);
        check("midrst_desc", bus.eng_desc_o, 0);
        check("midrst_outs", {bus.ch_grant_o, bus.ch_done_o, bus.ch_err_o, bus.eng_go_o, bus.eng_abort_o}, 0);
        rst            = 1'b0;
        bus.eng_busy_i = 1'b0;
        bus.ch_req_i   = 4'b1001;
        expect_ev(EV_GRANT, 0, s + 6);
        expect_ev(EV_GO, -1, s + 7);
        expect_ev(EV_DONE, 0, s + 11);
        expect_ev(EV_GRANT, 3, s + 12);
        expect_ev(EV_GO, -1, s + 13);
        expect_ev(EV_DONE, 3, s + 16);
        wait_cyc(s + 7);
        bus.ch_req_i   = 4'b1000;
        bus.eng_busy_i = 1'b1;
        wait_cyc(s + 10);
        bus.eng_done_i = 1'b1;
        bus.eng_busy_i = 1'b0;
        wait_cyc(s + 11);
        bus.eng_done_i = 1'b0;
        wait_cyc(s + 13);
        bus.ch_req_i   = '0;
        bus.eng_busy_i = 1'b1;
        wait_cyc(s + 15);
        bus.eng_done_i = 1'b1;
        bus.eng_busy_i = 1'b0;
        wait_cyc(s + 16);
        bus.eng_done_i = 1'b0;
        wait_cyc(s + 18);

`ifdef DMA_SCHED_PRIO_EN
        // High-priority channel 3 served repeatedly; channel 0 only after prio clears.
        s = cyc;
        bus.ch_req_i  = 4'b1111;
        bus.ch_prio_i = 4'b1000;
        for (int k = 0; k < 2; k++) begin
            expect_ev(EV_GRANT, 3, s + 1 + 8*k);
            expect_ev(EV_GO, -1, s + 2 + 8*k);
            expect_ev(EV_DONE, 3, s + 8 + 8*k);
        end
        expect_ev(EV_GRANT, 0, s + 17);
        expect_ev(EV_GO, -1, s + 18);
        expect_ev(EV_DONE, 0, s + 24);
        for (int k = 0; k < 2; k++) begin
            wait_cyc(s + 2 + 8*k);
            bus.eng_busy_i = 1'b1;
            if (k == 1) bus.ch_prio_i = '0;
            wait_cyc(s + 7 + 8*k);
            bus.eng_done_i = 1'b1;
            bus.eng_busy_i = 1'b0;
            wait_cyc(s + 8 + 8*k);
            bus.eng_done_i = 1'b0;
        end
        wait_cyc(s + 18);
        bus.ch_req_i   = '0;
        bus.eng_busy_i = 1'b1;
        wait_cyc(s + 23);
        bus.eng_done_i = 1'b1;
        bus.eng_busy_i = 1'b0;
        wait_cyc(s + 24);
        bus.eng_done_i = 1'b0;
        wait_cyc(s + 26);
`endif

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
